// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter for the single write port of Mem between two requesters.
// After reset it optionally sweeps every address with zero before taking traffic.
module mem_write_arbiter #(
   parameter int unsigned ADDR_SIZE      = 4,
   parameter int unsigned BYTE_SIZE      = 8,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 req0,
   input  logic [ADDR_SIZE-1:0] addr0,
   input  logic [BYTE_SIZE-1:0] data0,
   output logic                 gnt0,
   input  logic                 req1,
   input  logic [ADDR_SIZE-1:0] addr1,
   input  logic [BYTE_SIZE-1:0] data1,
   output logic                 gnt1,
   output logic                 busy,
   output logic                 wen,
   output logic [ADDR_SIZE-1:0] waddr,
   output logic [BYTE_SIZE-1:0] wdata
);

   typedef enum logic {StInit, StRun} state_e;

   state_e               state;
   logic                 prio;
   logic [ADDR_SIZE-1:0] cnt;

   logic elig0, elig1, any_elig, pick1;

   // A requester whose grant is currently showing is masked so a held request
   // is not written twice.
   always_comb begin
      elig0    = req0 & ~gnt0;
      elig1    = req1 & ~gnt1;
      any_elig = elig0 | elig1;
      pick1    = elig1 & (~elig0 | prio);
   end

   assign busy = (state == StInit);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= CLEAR_ON_RESET ? StInit : StRun;
         prio  <= 1'b0;
         cnt   <= '0;
         wen   <= 1'b0;
         waddr <= '0;
         wdata <= '0;
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
      end else begin
         unique case (state)
            StInit: begin
               wen   <= 1'b1;
               waddr <= cnt;
               wdata <= '0;
               gnt0  <= 1'b0;
               gnt1  <= 1'b0;
               cnt   <= cnt + 1'b1;
               if (cnt == '1) begin
                  state <= StRun;
               end
            end
            StRun: begin
               if (any_elig) begin
                  wen   <= 1'b1;
                  gnt0  <= ~pick1;
                  gnt1  <= pick1;
                  prio  <= ~pick1;
                  waddr <= pick1 ? addr1 : addr0;
                  wdata <= pick1 ? data1 : data0;
               end else begin
                  wen  <= 1'b0;
                  gnt0 <= 1'b0;
                  gnt1 <= 1'b0;
               end
            end
            default: begin
               state <= StRun;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Bench for mem_write_arbiter: directed timing checks plus a randomized phase
// checked by a scoreboard and a round-robin reference model.
module tb_mem_write_arbiter;

   logic       clock;
   logic       reset_n;
   logic       req0, req1;
   logic [3:0] addr0, addr1;
   logic [7:0] data0, data1;
   logic       gnt0, gnt1, busy, wen;
   logic [3:0] waddr;
   logic [7:0] wdata;

   logic       b_req1;
   logic       b_gnt0, b_gnt1, b_busy, b_wen;
   logic [3:0] b_waddr;
   logic [7:0] b_wdata;

   int n_total = 0;
   int n_pass  = 0;

   logic [7:0]  mem [16];
   logic [11:0] q0[$];
   logic [11:0] q1[$];

   logic       mon_en = 1'b0;
   logic       pred_valid = 1'b0;
   logic       prio_m = 1'b0;
   logic [1:0] pred_gnt = 2'b00;

   mem_write_arbiter #(.ADDR_SIZE(4), .BYTE_SIZE(8), .CLEAR_ON_RESET(1'b1)) dut (
      .clock(clock), .reset_n(reset_n),
      .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
      .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
      .busy(busy), .wen(wen), .waddr(waddr), .wdata(wdata)
   );

   mem_write_arbiter #(.ADDR_SIZE(4), .BYTE_SIZE(8), .CLEAR_ON_RESET(1'b0)) dut_nc (
      .clock(clock), .reset_n(reset_n),
      .req0(1'b0), .addr0(4'd0), .data0(8'd0), .gnt0(b_gnt0),
      .req1(b_req1), .addr1(4'd7), .data1(8'h5A), .gnt1(b_gnt1),
      .busy(b_busy), .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) if (wen) mem[waddr] <= wdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Scoreboard monitor: grants must follow round-robin order and carry the
   // payload the requester queued when it raised its request.
   always @(negedge clock) begin
      if (!mon_en) begin
         pred_valid = 1'b0;
      end else begin
         if (pred_valid) begin
            chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
            chk("rr_winner", {30'd0, gnt1, gnt0}, {30'd0, pred_gnt});
            chk("wen_vs_grant", {31'd0, wen}, {31'd0, |pred_gnt});
            if (gnt0) begin
               if (q0.size() == 0) chk("q0_underflow", 32'd1, 32'd0);
               else chk("payload0", {20'd0, waddr, wdata}, {20'd0, q0.pop_front()});
               prio_m = 1'b1;
            end
            if (gnt1) begin
               if (q1.size() == 0) chk("q1_underflow", 32'd1, 32'd0);
               else chk("payload1", {20'd0, waddr, wdata}, {20'd0, q1.pop_front()});
               prio_m = 1'b0;
            end
         end
         begin
            logic e0, e1;
            e0 = req0 && !gnt0;
            e1 = req1 && !gnt1;
            if (e0 && e1) pred_gnt = prio_m ? 2'b10 : 2'b01;
            else pred_gnt = {e1, e0};
         end
         pred_valid = 1'b1;
      end
   end

   task automatic requester(input int id, input int n);
      for (int t = 0; t < n; t++) begin
         int idle;
         logic [3:0] a;
         logic [7:0] d;
         logic got;
         idle = $urandom_range(0, 2);
         if (idle > 0) begin
            if (id == 0) req0 = 1'b0; else req1 = 1'b0;
            repeat (idle) step();
         end
         a = 4'($urandom_range(0, 15));
         d = 8'($urandom);
         if (id == 0) begin
            addr0 = a; data0 = d; req0 = 1'b1; q0.push_back({a, d});
         end else begin
            addr1 = a; data1 = d; req1 = 1'b1; q1.push_back({a, d});
         end
         got = 1'b0;
         for (int w = 0; w < 20 && !got; w++) begin
            step();
            got = (id == 0) ? gnt0 : gnt1;
         end
         if (!got) begin
            chk("req_timeout", 32'd0, 32'd1);
            break;
         end
      end
      if (id == 0) req0 = 1'b0; else req1 = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      req0 = 1'b1; addr0 = 4'd3; data0 = 8'hA5;
      req1 = 1'b0; addr1 = 4'd0; data1 = 8'h00;
      b_req1 = 1'b1;
      #22;
      chk("rst_wen", {31'd0, wen}, 32'd0);
      chk("rst_waddr", {28'd0, waddr}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
      chk("nc_rst_busy", {31'd0, b_busy}, 32'd0);
      chk("nc_rst_gnt1", {31'd0, b_gnt1}, 32'd0);

      // Clear pass with req0 held throughout
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("clr_wen", {31'd0, wen}, 32'd1);
         chk("clr_waddr", {28'd0, waddr}, i);
         chk("clr_wdata", {24'd0, wdata}, 32'd0);
         chk("clr_gnt0", {31'd0, gnt0}, 32'd0);
         chk("clr_busy", {31'd0, busy}, (i < 15) ? 32'd1 : 32'd0);
         chk("nc_busy", {31'd0, b_busy}, 32'd0);
         if (i == 0) begin
            chk("nc_first_gnt1", {31'd0, b_gnt1}, 32'd1);
            b_req1 = 1'b0;
         end
      end

      // Single held requester: granted every other cycle
      for (int k = 0; k < 5; k++) begin
         step();
         chk("single_gnt0", {31'd0, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("single_wen", {31'd0, wen}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("single_waddr", {28'd0, waddr}, 32'd3);
         chk("single_wdata", {24'd0, wdata}, 32'hA5);
      end
      req0 = 1'b0;
      step();

      // Contention from RUN entry with prio 0
      reset_n = 1'b0;
      #2;
      req0 = 1'b1; addr0 = 4'd1; data0 = 8'h10;
      req1 = 1'b1; addr1 = 4'd2; data1 = 8'h20;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (16) step();
      for (int k = 0; k < 6; k++) begin
         step();
         chk("cont_gnt0", {31'd0, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("cont_gnt1", {31'd0, gnt1}, (k % 2 == 1) ? 32'd1 : 32'd0);
         chk("cont_wen", {31'd0, wen}, 32'd1);
      end
      req1 = 1'b0;
      step();
      chk("same_pre_gnt0", {31'd0, gnt0}, 32'd1);
      addr0 = 4'd5; data0 = 8'h11;
      req1 = 1'b1; addr1 = 4'd5; data1 = 8'h22;
      step();
      chk("same_first_gnt1", {31'd0, gnt1}, 32'd1);
      chk("same_first_data", {24'd0, wdata}, 32'h22);
      req1 = 1'b0;
      step();
      chk("same_second_gnt0", {31'd0, gnt0}, 32'd1);
      chk("same_second_data", {24'd0, wdata}, 32'h11);
      req0 = 1'b0;
      step();
      chk("same_idle_wen", {31'd0, wen}, 32'd0);
      chk("same_mem5", {24'd0, mem[5]}, 32'h11);

      // Reset asserted while a grant to requester 1 is showing
      req1 = 1'b1; addr1 = 4'd9; data1 = 8'h3C;
      step();
      chk("mid_pre_gnt1", {31'd0, gnt1}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_wen", {31'd0, wen}, 32'd0);
      chk("mid_gnt1", {31'd0, gnt1}, 32'd0);
      chk("mid_waddr", {28'd0, waddr}, 32'd0);
      chk("mid_wdata", {24'd0, wdata}, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      req1 = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      step();
      chk("restart_waddr", {28'd0, waddr}, 32'd0);
      chk("restart_wen", {31'd0, wen}, 32'd1);
      chk("restart_busy", {31'd0, busy}, 32'd1);

      // Randomized traffic against the scoreboard
      begin
         int guard = 0;
         while (busy && guard < 40) begin
            step();
            guard++;
         end
         chk("clear_done", {31'd0, busy}, 32'd0);
      end
      prio_m = 1'b0;
      mon_en = 1'b1;
      fork
         requester(0, 60);
         requester(1, 60);
      join
      repeat (3) step();
      mon_en = 1'b0;
      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
